pwm_deadtime_gen: RTL and testbench
===================================

// Module: pwm_deadtime_gen
// PURPOSE
//  Downstream stage of the PWM peripheral: consumes per-channel PWM + output-enable from the PWM
//  top level and produces complementary high-side/low-side gate drives with programmable dead time.
//  Both drives of a channel are never high in the same cycle. Same clock domain as the PWM, no CDC.
// PARAMETERS
//  NCH  2  number of PWM channels (channel 0 = pwm_o, channel 1 = pwm_o_2)
//  DTW  8  width of dead-time count fields
// PORTS
//  clk_i        in   1    system clock
//  rst_ni       in   1    asynchronous active-low reset
//  en_i         in   1    global enable; 0 forces all channels to OFF
//  pwm_i        in   NCH  PWM waveform per channel, synchronous to clk_i
//  pwm_oe_i     in   NCH  PWM output-enable per channel
//  dt_rise_i    in   DTW  dead-time cycles inserted before high-side turn-on (shared by all channels)
//  dt_fall_i    in   DTW  dead-time cycles inserted before low-side turn-on (shared)
//  hs_o         out  NCH  high-side drive
//  ls_o         out  NCH  low-side drive
//  drv_oe_o     out  NCH  drive output-enable (1 when channel state != OFF)
//  fault_i      in   1    [PWM_DT_FAULT_EN only] level fault input
//  fault_clr_i  in   1    [PWM_DT_FAULT_EN only] single-cycle fault clear pulse
//  fault_o      out  1    [PWM_DT_FAULT_EN only] sticky fault flag
// BEHAVIOUR
//  - Reset: all outputs 0, every channel in OFF, counters 0. Async reset mid-operation drops outputs immediately.
//  - Per-channel Moore FSM; hs_o/ls_o/drv_oe_o are registered decodes of next state (no glitches).
//    OFF     hs=0 ls=0 oe=0. act = en_i & pwm_oe_i[c]. act & !pwm_i -> LS_ON; act & pwm_i -> DT_RISE (cnt<=dt_rise_i)
//    LS_ON   hs=0 ls=1. pwm_i=1 -> DT_RISE, cnt<=dt_rise_i
//    DT_RISE hs=0 ls=0. pwm_i=0 -> LS_ON (abort); else cnt==0 -> HS_ON; else cnt<=cnt-1
//    HS_ON   hs=1 ls=0. pwm_i=0 -> DT_FALL, cnt<=dt_fall_i
//    DT_FALL hs=0 ls=0. pwm_i=1 -> HS_ON (abort); else cnt==0 -> LS_ON; else cnt<=cnt-1
//    Any state: !act -> OFF next cycle (highest priority after fault).
//  - Timing: pwm_i rises in cycle t -> ls_o falls at t+1; hs_o rises at t+2+dt_rise_i. Symmetric for fall.
//    Minimum dead time is 1 cycle even with dt_*_i=0.
//  - dt_rise_i/dt_fall_i sampled only on entry to DT_*; changes mid-dead-time have no effect until next edge.
//  - Pulse shorter than dead time: abort path returns to previous side; opposite side never asserted.
//  - Invariant: (hs_o & ls_o) == 0 every cycle, every channel.
// CONFIGURATION
//  PWM_DT_FAULT_EN defined: fault ports exist; fault_i=1 -> all channels enter FAULT next cycle
//    (hs=ls=oe=0), fault_o=1 sticky. FAULT exits to OFF only on fault_clr_i=1 while fault_i=0.
//    fault_clr_i while fault_i=1 is ignored. Fault has priority over all transitions.
//  PWM_DT_FAULT_EN undefined: fault ports, FAULT state and fault_o absent; behaviour otherwise identical.
// STRUCTURE
//  pwm_dt_pkg: typedef enum logic [2:0] dt_state_e {OFF, LS_ON, DT_RISE, HS_ON, DT_FALL, FAULT};
//    DTW default constant.
//  Sub-module pwm_dt_chan: one channel FSM + down-counter; top generates NCH instances, holds
//    act gating and (if enabled) shared fault latch.
// TESTING
//  1 Reset with pwm_i=1, oe=1 -> hs_o=ls_o=drv_oe_o=0 until rst_ni release; first cycle after release still 0.
//  2 en=1, oe=1, dt_rise=3, dt_fall=2, pwm_i 0->1 at t -> ls_o=0 at t+1, hs_o=1 at t+5; fall at u -> ls_o=1 at u+4.
//  3 dt_rise=5, 2-cycle pwm_i high pulse -> hs_o never 1, ls_o back to 1; assert hs&ls==0 throughout.
//  4 dt_rise=0, dt_fall=0 -> exactly 1 cycle both-low gap on each edge.
//  5 Drop pwm_oe_i[1] while ch1 in HS_ON -> ch1 outputs 0 next cycle, ch0 unaffected.
//  6 [PWM_DT_FAULT_EN] fault_i pulse mid-HS_ON -> all outputs 0, fault_o=1; clr while fault_i=1 ignored;
//    clr after -> OFF then LS_ON.

Source files
------------

// File: rtl/pwm_dt_pkg.sv
// Shared types and defaults for the PWM dead-time generator.
// Used by both builds, with and without PWM_DT_FAULT_EN.
package pwm_dt_pkg;

  localparam int NCH_DEFAULT = 2;
  localparam int DTW_DEFAULT = 8;

  typedef enum logic [2:0] {
    OFF,
    LS_ON,
    DT_RISE,
    HS_ON,
    DT_FALL,
    FAULT
  } dt_state_e;

  // A channel drives its gate pins in every state except OFF and FAULT.
  function automatic logic isDriving(input dt_state_e s);
    return (s != OFF) && (s != FAULT);
  endfunction

endpackage

// File: rtl/pwm_dt_chan.sv
// One channel of complementary gate drive with dead-time insertion.
// With PWM_DT_FAULT_EN defined, a FAULT state is added that overrides every other transition.
module pwm_dt_chan
  import pwm_dt_pkg::*;
#(
  parameter int DTW = DTW_DEFAULT
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           act_i,
  input  logic           pwm_i,
  input  logic [DTW-1:0] dt_rise_i,
  input  logic [DTW-1:0] dt_fall_i,
`ifdef PWM_DT_FAULT_EN
  input  logic           fault_i,
  input  logic           fault_clr_i,
`endif
  output logic           hs_o,
  output logic           ls_o,
  output logic           drv_oe_o
);

  dt_state_e      state_q, state_d;
  logic [DTW-1:0] cnt_q, cnt_d;
  logic           hs_q, ls_q, oe_q;
  logic           hs_d, ls_d, oe_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OFF;
      cnt_q   <= '0;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hs_q    <= hs_d;
      ls_q    <= ls_d;
      oe_q    <= oe_d;
    end
  end

  // The dead-time length is captured only on entry to DT_*, so later changes wait for the next edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef PWM_DT_FAULT_EN
    if (fault_i) begin
      state_d = FAULT;
    end else if (state_q == FAULT) begin
      if (fault_clr_i) state_d = OFF;
    end else
`endif
    if (!act_i) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF: begin
          if (pwm_i) begin
            state_d = DT_RISE;
            cnt_d   = dt_rise_i;
          end else begin
            state_d = LS_ON;
          end
        end
        LS_ON: begin
          if (pwm_i) begin
            state_d = DT_RISE;
            cnt_d   = dt_rise_i;
          end
        end
        DT_RISE: begin
          if (!pwm_i)           state_d = LS_ON;
          else if (cnt_q == '0) state_d = HS_ON;
          else                  cnt_d   = cnt_q - DTW'(1);
        end
        HS_ON: begin
          if (!pwm_i) begin
            state_d = DT_FALL;
            cnt_d   = dt_fall_i;
          end
        end
        DT_FALL: begin
          if (pwm_i)            state_d = HS_ON;
          else if (cnt_q == '0) state_d = LS_ON;
          else                  cnt_d   = cnt_q - DTW'(1);
        end
        default: state_d = OFF;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they change glitch-free with the state.
  always_comb begin
    hs_d = (state_d == HS_ON);
    ls_d = (state_d == LS_ON);
    oe_d = isDriving(state_d);
  end

  assign hs_o     = hs_q;
  assign ls_o     = ls_q;
  assign drv_oe_o = oe_q;

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low-side gate drive generator with per-channel dead time.
// Define PWM_DT_FAULT_EN to add the fault_i / fault_clr_i / fault_o ports and the shared fault latch.
module pwm_deadtime_gen
  import pwm_dt_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT,
  parameter int DTW = DTW_DEFAULT
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_i,
  input  logic [NCH-1:0] pwm_i,
  input  logic [NCH-1:0] pwm_oe_i,
  input  logic [DTW-1:0] dt_rise_i,
  input  logic [DTW-1:0] dt_fall_i,
  output logic [NCH-1:0] hs_o,
  output logic [NCH-1:0] ls_o,
  output logic [NCH-1:0] drv_oe_o
`ifdef PWM_DT_FAULT_EN
  ,
  input  logic           fault_i,
  input  logic           fault_clr_i,
  output logic           fault_o
`endif
);

  logic [NCH-1:0] act;

  assign act = pwm_oe_i & {NCH{en_i}};

`ifdef PWM_DT_FAULT_EN
  logic fault_q, fault_d;

  // Sticky flag: a clear pulse is honoured only once the fault input has gone away.
  always_comb begin
    fault_d = fault_q;
    if (fault_i)          fault_d = 1'b1;
    else if (fault_clr_i) fault_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fault_q <= 1'b0;
    else         fault_q <= fault_d;
  end

  assign fault_o = fault_q;
`endif

  for (genvar c = 0; c < NCH; c++) begin : gChan
    pwm_dt_chan #(
      .DTW(DTW)
    ) uChan (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .act_i      (act[c]),
      .pwm_i      (pwm_i[c]),
      .dt_rise_i  (dt_rise_i),
      .dt_fall_i  (dt_fall_i),
`ifdef PWM_DT_FAULT_EN
      .fault_i    (fault_i),
      .fault_clr_i(fault_clr_i),
`endif
      .hs_o       (hs_o[c]),
      .ls_o       (ls_o[c]),
      .drv_oe_o   (drv_oe_o[c])
    );
  end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed scoreboard bench for pwm_deadtime_gen; fault steps are included when PWM_DT_FAULT_EN is defined.
// Expected channel states: O=off, L=low side on, D=dead time (both low, enabled), H=high side on.
module tb_pwm_deadtime_gen;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_i;
  logic [1:0] pwm_i;
  logic [1:0] pwm_oe_i;
  logic [7:0] dt_rise_i;
  logic [7:0] dt_fall_i;
  logic [1:0] hs_o;
  logic [1:0] ls_o;
  logic [1:0] drv_oe_o;
`ifdef PWM_DT_FAULT_EN
  logic       fault_i;
  logic       fault_clr_i;
  logic       fault_o;
`endif

  typedef struct {
    logic [1:0] hs;
    logic [1:0] ls;
    logic [1:0] oe;
    string      tag;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nPassed = 0;
  int   nFailed = 0;
  bit   invOn   = 1'b0;

  pwm_deadtime_gen #(
    .NCH(2),
    .DTW(8)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .pwm_i      (pwm_i),
    .pwm_oe_i   (pwm_oe_i),
    .dt_rise_i  (dt_rise_i),
    .dt_fall_i  (dt_fall_i),
    .hs_o       (hs_o),
    .ls_o       (ls_o),
    .drv_oe_o   (drv_oe_o)
`ifdef PWM_DT_FAULT_EN
    ,
    .fault_i    (fault_i),
    .fault_clr_i(fault_clr_i),
    .fault_o    (fault_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Both drives of a channel high at once is never allowed, whatever the stimulus.
  always @(negedge clk_i) begin
    if (invOn && rst_ni === 1'b1) begin
      nChecks++;
      assert ((hs_o & ls_o) === 2'b00) nPassed++;
      else begin
        nFailed++;
        $error("[TB] FAIL shoot_through observed hs=%b ls=%b expected hs&ls=00", hs_o, ls_o);
      end
    end
  end

  function automatic exp_t decode(input string states, input string tag);
    exp_t e;
    e.hs  = 2'b00;
    e.ls  = 2'b00;
    e.oe  = 2'b00;
    e.tag = tag;
    for (int c = 0; c < 2; c++) begin
      case (states[c])
        "L": begin e.ls[c] = 1'b1; e.oe[c] = 1'b1; end
        "D": e.oe[c] = 1'b1;
        "H": begin e.hs[c] = 1'b1; e.oe[c] = 1'b1; end
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [1:0] observed, input logic [1:0] expected);
    nChecks++;
    assert (observed === expected) nPassed++;
    else begin
      nFailed++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    e = expQ.pop_front();
    cmp({e.tag, ".hs"}, hs_o, e.hs);
    cmp({e.tag, ".ls"}, ls_o, e.ls);
    cmp({e.tag, ".oe"}, drv_oe_o, e.oe);
  endtask

  // states[0] is channel 0, states[1] is channel 1; expectations apply after the next clock edge.
  task automatic applyStimulus(input logic en, input logic [1:0] oe, input logic [1:0] pwm,
                               input string states, input string tag, input bit clock = 1'b1);
    en_i     = en;
    pwm_oe_i = oe;
    pwm_i    = pwm;
    expQ.push_back(decode(states, tag));
    if (clock) @(posedge clk_i);
    #1;
    checkOutput();
  endtask

`ifdef PWM_DT_FAULT_EN
  task automatic checkFault(input logic expected, input string tag);
    cmp(tag, {1'b0, fault_o}, {1'b0, expected});
  endtask
`endif

  initial begin
    rst_ni    = 1'b0;
    en_i      = 1'b1;
    pwm_oe_i  = 2'b11;
    pwm_i     = 2'b11;
    dt_rise_i = 8'd3;
    dt_fall_i = 8'd2;
`ifdef PWM_DT_FAULT_EN
    fault_i     = 1'b0;
    fault_clr_i = 1'b0;
`endif
    #2;
    $display("[TB] reset with pwm and oe high");
    repeat (3) applyStimulus(1'b1, 2'b11, 2'b11, "OO", "rst_hold");
`ifdef PWM_DT_FAULT_EN
    checkFault(1'b0, "rst_fault");
`endif
    rst_ni = 1'b1;
    applyStimulus(1'b1, 2'b11, 2'b11, "OO", "rst_release", 1'b0);
    invOn = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b11, 2'b11, "DD", "off_dtr");
    applyStimulus(1'b1, 2'b11, 2'b11, "HH", "off_hs");

    $display("[TB] dead time rise=3 fall=2");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b11, 2'b00, "DD", "dtf2_gap");
    applyStimulus(1'b1, 2'b11, 2'b00, "LL", "dtf2_ls");
    applyStimulus(1'b1, 2'b11, 2'b00, "LL", "dtf2_hold");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b11, 2'b11, "DD", "dtr3_gap");
    applyStimulus(1'b1, 2'b11, 2'b11, "HH", "dtr3_hs");
    applyStimulus(1'b1, 2'b11, 2'b11, "HH", "dtr3_hold");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b11, 2'b00, "DD", "fall_gap");
    applyStimulus(1'b1, 2'b11, 2'b00, "LL", "fall_ls");

    $display("[TB] pulse shorter than dead time");
    dt_rise_i = 8'd5;
    applyStimulus(1'b1, 2'b11, 2'b11, "DD", "short_dt0");
    applyStimulus(1'b1, 2'b11, 2'b11, "DD", "short_dt1");
    applyStimulus(1'b1, 2'b11, 2'b00, "LL", "short_abort");
    applyStimulus(1'b1, 2'b11, 2'b00, "LL", "short_hold");

    $display("[TB] dead time sampled on entry only");
    dt_rise_i = 8'd1;
    applyStimulus(1'b1, 2'b11, 2'b11, "DD", "entry_dt0");
    dt_rise_i = 8'd7;
    applyStimulus(1'b1, 2'b11, 2'b11, "DD", "entry_dt1");
    applyStimulus(1'b1, 2'b11, 2'b11, "HH", "entry_hs");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b11, 2'b00, "DD", "entry_fall");
    applyStimulus(1'b1, 2'b11, 2'b00, "LL", "entry_ls");

    $display("[TB] zero dead time keeps a one-cycle gap");
    dt_rise_i = 8'd0;
    dt_fall_i = 8'd0;
    applyStimulus(1'b1, 2'b11, 2'b11, "DD", "zero_rgap");
    applyStimulus(1'b1, 2'b11, 2'b11, "HH", "zero_hs");
    applyStimulus(1'b1, 2'b11, 2'b11, "HH", "zero_hshold");
    applyStimulus(1'b1, 2'b11, 2'b00, "DD", "zero_fgap");
    applyStimulus(1'b1, 2'b11, 2'b00, "LL", "zero_ls");
    applyStimulus(1'b1, 2'b11, 2'b00, "LL", "zero_lshold");

    $display("[TB] per-channel output enable");
    applyStimulus(1'b1, 2'b11, 2'b11, "DD", "oe_gap");
    applyStimulus(1'b1, 2'b11, 2'b11, "HH", "oe_hs");
    applyStimulus(1'b1, 2'b01, 2'b11, "HO", "oe_drop1");
    applyStimulus(1'b1, 2'b01, 2'b11, "HO", "oe_drop1_hold");
    applyStimulus(1'b1, 2'b11, 2'b11, "HD", "oe_reen");
    applyStimulus(1'b1, 2'b11, 2'b11, "HH", "oe_reen_hs");
    applyStimulus(1'b0, 2'b11, 2'b11, "OO", "en_off");
    applyStimulus(1'b1, 2'b11, 2'b00, "LL", "en_on_ls");

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(1'b1, 2'b11, 2'b11, "DD", "arst_gap");
    applyStimulus(1'b1, 2'b11, 2'b11, "HH", "arst_hs");
    rst_ni = 1'b0;
    applyStimulus(1'b1, 2'b11, 2'b11, "OO", "arst_now", 1'b0);
    applyStimulus(1'b1, 2'b11, 2'b11, "OO", "arst_hold");
    rst_ni = 1'b1;
    applyStimulus(1'b1, 2'b11, 2'b00, "LL", "arst_release");

`ifdef PWM_DT_FAULT_EN
    $display("[TB] fault latch and clear");
    applyStimulus(1'b1, 2'b11, 2'b11, "DD", "flt_gap");
    applyStimulus(1'b1, 2'b11, 2'b11, "HH", "flt_hs");
    fault_i = 1'b1;
    applyStimulus(1'b1, 2'b11, 2'b11, "OO", "flt_enter");
    checkFault(1'b1, "flt_set");
    fault_i = 1'b0;
    applyStimulus(1'b1, 2'b11, 2'b11, "OO", "flt_sticky");
    checkFault(1'b1, "flt_sticky_flag");
    fault_i     = 1'b1;
    fault_clr_i = 1'b1;
    applyStimulus(1'b1, 2'b11, 2'b11, "OO", "flt_clr_ignored");
    checkFault(1'b1, "flt_clr_ignored_flag");
    fault_i     = 1'b0;
    fault_clr_i = 1'b0;
    applyStimulus(1'b1, 2'b11, 2'b00, "OO", "flt_still");
    checkFault(1'b1, "flt_still_flag");
    fault_clr_i = 1'b1;
    applyStimulus(1'b1, 2'b11, 2'b00, "OO", "flt_clr_off");
    checkFault(1'b0, "flt_cleared_flag");
    fault_clr_i = 1'b0;
    applyStimulus(1'b1, 2'b11, 2'b00, "LL", "flt_resume_ls");
`endif

    invOn = 1'b0;
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
